// File: rtl/seq_mult_ram_pkg.sv
// Shared definitions for the RAM-backed sequential multiplier.
// State encoding is visible on st_debug, so the values are fixed.
package seq_mult_ram_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_B  = 3'd2,
    S_LD_B  = 3'd3,
    S_MULT  = 3'd4,
    S_WR_LO = 3'd5,
    S_WR_HI = 3'd6,
    S_DONE  = 3'd7
  } st_e;

endpackage

// File: rtl/seq_mult_ram_mem.sv
// 1W/2R synchronous RAM; reads return pre-write data on collision.
// Storage is not reset; only the read registers are.
module seq_mult_ram_mem
  import seq_mult_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr0,
  output logic [DATA_W-1:0] o_rdata0,
  input  logic [ADDR_W-1:0] i_raddr1,
  output logic [DATA_W-1:0] o_rdata1
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rd0;
  logic [DATA_W-1:0] r_rd1;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd0 <= '0;
      r_rd1 <= '0;
    end else begin
      r_rd0 <= r_mem[i_raddr0];
      r_rd1 <= r_mem[i_raddr1];
    end
  end

  assign o_rdata0 = r_rd0;
  assign o_rdata1 = r_rd1;

endmodule

// File: rtl/seq_mult_ram.sv
// Sequential shift-add multiplier with operands and product in RAM.
// Signed mode multiplies magnitudes and negates the final product.
module seq_mult_ram
  import seq_mult_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              signed_mode,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_p,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [ADDR_W-1:0] obs_addr,
  output logic [DATA_W-1:0] ram_out,
  output logic              busy,
  output logic              done,
  output logic [ST_W-1:0]   st_debug
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] ONE_D = 1;
  localparam logic [PROD_W-1:0] ONE_P = 1;
  localparam logic [ADDR_W-1:0] ONE_A = 1;

  st_e               r_state;
  st_e               w_next;
  logic [ADDR_W-1:0] r_addr_a;
  logic [ADDR_W-1:0] r_addr_b;
  logic [ADDR_W-1:0] r_addr_p;
  logic              r_signed;
  logic [DATA_W-1:0] r_a;
  logic [PROD_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [PROD_W-1:0] r_acc;
  logic              r_neg;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [ADDR_W-1:0] w_raddr;
  logic [DATA_W-1:0] w_rdata;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [DATA_W-1:0] w_a_mag;
  logic [DATA_W-1:0] w_b_mag;
  logic [PROD_W-1:0] w_step;
  logic [PROD_W-1:0] w_prod;
  logic              w_last;

  seq_mult_ram_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr0(w_raddr),
    .o_rdata0(w_rdata),
    .i_raddr1(obs_addr),
    .o_rdata1(ram_out)
  );

  assign w_raddr = (r_state == S_RD_B) ? r_addr_b : r_addr_a;

  // Inverting the most-negative value wraps to itself, which is the
  // correct unsigned magnitude 2**(DATA_W-1).
  assign w_a_neg = r_signed & r_a[DATA_W-1];
  assign w_b_neg = r_signed & w_rdata[DATA_W-1];
  assign w_a_mag = w_a_neg ? (~r_a + ONE_D) : r_a;
  assign w_b_mag = w_b_neg ? (~w_rdata + ONE_D) : w_rdata;

  assign w_step = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_prod = r_neg ? (~w_step + ONE_P) : w_step;
  assign w_last = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_waddr = host_addr;
    w_wdata = host_wdata;
    unique case (r_state)
      S_IDLE: begin
        w_we = host_we;
        if (start) w_next = S_RD_A;
      end
      S_RD_A: w_next = S_RD_B;
      S_RD_B: w_next = S_LD_B;
      S_LD_B: w_next = S_MULT;
      S_MULT: if (w_last) w_next = S_WR_LO;
      S_WR_LO: begin
        w_we    = 1'b1;
        w_waddr = r_addr_p;
        w_wdata = r_acc[DATA_W-1:0];
        w_next  = S_WR_HI;
      end
      S_WR_HI: begin
        w_we    = 1'b1;
        w_waddr = r_addr_p + ONE_A;
        w_wdata = r_acc[PROD_W-1:DATA_W];
        w_next  = S_DONE;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_addr_p <= '0;
      r_signed <= 1'b0;
      r_a      <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr_a <= addr_a;
            r_addr_b <= addr_b;
            r_addr_p <= addr_p;
            r_signed <= signed_mode;
          end
        end
        S_RD_B: r_a <= w_rdata;
        S_LD_B: begin
          r_mcand  <= {{DATA_W{1'b0}}, w_a_mag};
          r_mplier <= w_b_mag;
          r_acc    <= '0;
          r_neg    <= w_a_neg ^ w_b_neg;
          r_cnt    <= CNT_W'(DATA_W);
        end
        S_MULT: begin
          r_acc    <= w_last ? w_prod : w_step;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign st_debug = r_state;

endmodule

// File: tb/tb_seq_mult_ram.sv
// Bench for seq_mult_ram: cycle model of the handshake and RAM,
// directed operand vectors and literal product checks.
module tb_seq_mult_ram;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          signed_mode = 1'b0;
  logic [AW-1:0] addr_a = '0;
  logic [AW-1:0] addr_b = '0;
  logic [AW-1:0] addr_p = '0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic [AW-1:0] obs_addr = '0;
  logic [DW-1:0] ram_out;
  logic          busy;
  logic          done;
  logic [2:0]    st_debug;

  int n_pass = 0;
  int n_tot = 0;
  bit cmp_en = 0;

  always #5 clk = ~clk;

  seq_mult_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .signed_mode(signed_mode),
    .addr_a     (addr_a),
    .addr_b     (addr_b),
    .addr_p     (addr_p),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .obs_addr   (obs_addr),
    .ram_out    (ram_out),
    .busy       (busy),
    .done       (done),
    .st_debug   (st_debug)
  );

  task automatic chk(input string nm, input int got, input int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
  endtask

  function automatic logic [2*DW-1:0] ref_mul(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b,
                                               input logic sm);
    int r;
    if (sm) r = int'($signed(a)) * int'($signed(b));
    else r = int'(a) * int'(b);
    return r[2*DW-1:0];
  endfunction

  // Phase k counts cycles since start: 1 RD_A, 2 RD_B, 3 LD_B,
  // 4..DW+3 MULT, then WR_LO, WR_HI, DONE.
  function automatic int exp_st(input int k);
    if (k <= 3) return k;
    if (k <= DW + 3) return 4;
    return k - DW + 1;
  endfunction

  logic [DW-1:0]   m_mem [16];
  bit              m_known [16];
  int              m_k = 0;
  logic [DW-1:0]   m_ro = '0;
  bit              m_ro_known = 1;
  logic [AW-1:0]   m_p = '0;
  logic [2*DW-1:0] m_prod = '0;

  initial begin
    logic [DW-1:0] rd;
    bit rk;
    logic [AW-1:0] ph;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_k = 0;
        m_ro = '0;
        m_ro_known = 1;
      end else begin
        rd = m_mem[obs_addr];
        rk = m_known[obs_addr];
        if (m_k == 0) begin
          if (host_we) begin
            m_mem[host_addr] = host_wdata;
            m_known[host_addr] = 1;
          end
          if (start) begin
            m_prod = ref_mul(m_mem[addr_a], m_mem[addr_b], signed_mode);
            m_p = addr_p;
            m_k = 1;
          end
        end else begin
          if (m_k == DW + 4) begin
            m_mem[m_p] = m_prod[DW-1:0];
            m_known[m_p] = 1;
          end
          if (m_k == DW + 5) begin
            ph = m_p + 4'd1;
            m_mem[ph] = m_prod[2*DW-1:DW];
            m_known[ph] = 1;
          end
          m_k = (m_k == DW + 6) ? 0 : m_k + 1;
        end
        m_ro = rd;
        m_ro_known = rk;
      end
    end
  end

  initial begin
    wait (cmp_en);
    forever begin
      @(negedge clk);
      chk("busy", int'(busy), int'(m_k != 0));
      chk("done", int'(done), int'(m_k == DW + 6));
      chk("st_debug", int'(st_debug), exp_st(m_k));
      if (m_ro_known) chk("ram_out", int'(ram_out), int'(m_ro));
    end
  end

  int st_log [20];
  int walk_exp [15] = '{1, 2, 3, 4, 4, 4, 4, 4, 4, 4, 4, 5, 6, 7, 0};

  task automatic hw(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_we = 1'b1;
    host_addr = a;
    host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic run(input logic [AW-1:0] a, input logic [AW-1:0] b,
                     input logic [AW-1:0] p, input logic sm,
                     output int lat);
    addr_a = a;
    addr_b = b;
    addr_p = p;
    signed_mode = sm;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    host_we = 1'b0;
    lat = 0;
    st_log[0] = int'(st_debug);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat < 19) st_log[lat] = int'(st_debug);
    end
    if (!done) chk("done_timeout", lat, DW + 5);
    @(negedge clk);
    if (lat < 19) st_log[lat + 1] = int'(st_debug);
  endtask

  task automatic rd_obs(input string nm, input logic [AW-1:0] a,
                        input int exp);
    obs_addr = a;
    @(negedge clk);
    chk(nm, int'(ram_out), exp);
  endtask

  initial begin
    int lat;
    int nd;
    #2 reset = 1'b0;
    @(negedge clk);
    cmp_en = 1;
    chk("rst_st", int'(st_debug), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ram_out", int'(ram_out), 0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);

    hw(0, 8'd13);
    hw(1, 8'd11);
    run(0, 1, 4, 0, lat);
    chk("latency", lat, 13);
    for (int i = 0; i < 15; i++) chk("st_walk", st_log[i], walk_exp[i]);
    rd_obs("u13x11_lo", 4, 8'h8F);
    rd_obs("u13x11_hi", 5, 8'h00);

    hw(2, 8'd255);
    run(2, 2, 6, 0, lat);
    rd_obs("u255sq_lo", 6, 8'h01);
    rd_obs("u255sq_hi", 7, 8'hFE);
    run(2, 2, 6, 1, lat);
    rd_obs("s-1sq_lo", 6, 8'h01);
    rd_obs("s-1sq_hi", 7, 8'h00);

    hw(3, 8'hFD);
    hw(8, 8'd5);
    run(3, 8, 9, 1, lat);
    rd_obs("s-3x5_lo", 9, 8'hF1);
    rd_obs("s-3x5_hi", 10, 8'hFF);
    hw(10, 8'h80);
    hw(12, 8'd127);
    run(10, 10, 13, 1, lat);
    rd_obs("s-128sq_lo", 13, 8'h00);
    rd_obs("s-128sq_hi", 14, 8'h40);
    run(10, 12, 14, 1, lat);
    rd_obs("s-128x127_lo", 14, 8'h80);
    rd_obs("s-128x127_hi", 15, 8'hC0);

    hw(15, 8'd6);
    run(15, 1, 15, 0, lat);
    rd_obs("wrap_lo", 15, 8'h42);
    rd_obs("wrap_hi", 0, 8'h00);

    hw(0, 8'd20);
    addr_a = 0;
    addr_b = 1;
    addr_p = 6;
    signed_mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    host_we = 1'b1;
    host_addr = 0;
    host_wdata = 8'd99;
    @(negedge clk);
    start = 1'b0;
    host_we = 1'b0;
    nd = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("done_once", nd, 1);
    rd_obs("busy_we_ign", 0, 20);
    rd_obs("busy_lo", 6, 8'hDC);
    rd_obs("busy_hi", 7, 8'h00);

    host_we = 1'b1;
    host_addr = 2;
    host_wdata = 8'd50;
    run(2, 8, 9, 0, lat);
    rd_obs("same_cyc_lo", 9, 8'hFA);
    rd_obs("same_cyc_hi", 10, 8'h00);

    addr_a = 3;
    addr_b = 8;
    addr_p = 4;
    signed_mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_st", int'(st_debug), 0);
    chk("abort_busy", int'(busy), 0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    rd_obs("abort_lo", 4, 8'h8F);
    rd_obs("abort_hi", 5, 8'h00);
    run(3, 8, 4, 0, lat);
    rd_obs("post_lo", 4, 8'hF1);
    rd_obs("post_hi", 5, 8'h04);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
